inst_encoder: RTL and testbench
===============================

# inst_encoder

Streaming program loader. Accepts assembled tokens (instruction, label definition, end-of-program) one per cycle and packs each instruction into the 9-bit machine word `{op[3:0], arg[4:0]}`. It writes those words sequentially into instruction memory and fills the 32-entry jump table with resolved 9-bit label targets. This produces the image that the instruction decoder later consumes through its opcode field and its `jump_index` → `Offset` lookup. It sits between the host/testbench program source and instruction memory plus the jump-table RAM.

## Interface
- `IMEM_DEPTH`, 512: instruction slots; PC is 9 bits, internal count is 10 bits.
- `JT_ENTRIES`, 32: jump table entries, indexed by the 5-bit arg.

Ports:
- `CLK` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin new load; honoured only in IDLE, DONE or ERR.
- `tok_valid` in 1: token valid.
- `tok_ready` out 1: block can accept a token.
- `tok_kind` in 2: 00 instruction, 01 label definition, 10 end, 11 illegal.
- `tok_op` in 4: opcode, using definitions package values (kMOVE…kOR).
- `tok_arg` in 5: operand, or label index for kBEO/kBEZ/kJUMP and for label tokens.
- `imem_we` out 1, `imem_addr` out 9, `imem_wdata` out 9: instruction memory write port.
- `jt_we` out 1, `jt_addr` out 5, `jt_wdata` out 9: jump table write port.
- `busy` out 1: state is LOAD, FINISH or CHECK.
- `done` out 1: load completed cleanly.
- `error` out 1, `error_code` out 2: 00 illegal kind, 01 overflow, 10 duplicate label, 11 undefined label.
- `inst_count` out 10: words written, including any appended HALT.

## Operation
- States: IDLE, LOAD, FINISH, CHECK, DONE, ERR.
- IDLE, DONE, ERR: on `start`, clear pc, `inst_count`, the `defined[31:0]` and `referenced[31:0]` bitmaps, the `last_halt` flag and the error fields, then go to LOAD.
- LOAD: `tok_ready`=1. A token is accepted when `tok_valid && tok_ready`.
  - Instruction: if pc==512, go to ERR with code 01 and write nothing. Otherwise write `{op,arg}` at pc, increment pc, set `last_halt`=(op==kHALT), and set `referenced[arg]` if op is kBEO, kBEZ or kJUMP.
  - Label: if pc==512, ERR 01. Otherwise, if `defined[arg]` is set, ERR 10 with no write. Otherwise write jt[arg]=pc[8:0] and set `defined[arg]`.
  - End: go to CHECK if `last_halt`, else to FINISH.
  - Kind 11: ERR 00.
- FINISH: if pc==512, ERR 01. Otherwise write `{kHALT,5'b0}` at pc, increment pc, then go to CHECK.
- CHECK: one cycle. If `referenced & ~defined` is nonzero, go to ERR 11, else to DONE.
- DONE: `done`=1 is held until `start`. ERR: `error`=1 and `error_code` are held until `start`.
- `start` is ignored in LOAD, FINISH and CHECK.
- Undefined jump table entries are never written. Forward references are legal; they are resolved by the end-of-program check.
- A label at the current pc targets the next instruction written. Multiple labels at the same pc are legal.
- `inst_count` always equals the pc count.

## Timing
- Reset values: state IDLE; `tok_ready`, `imem_we`, `jt_we`, `busy`, `done`, `error` = 0; `error_code`, `inst_count`, all address and data outputs = 0.
- Reset mid-load returns to IDLE immediately. Memory contents are not cleared.
- All outputs are registered. A token accepted in cycle N produces a one-cycle `imem_we` or `jt_we` pulse in cycle N+1, with address and data valid in that cycle. Both strobes are never high together.
- Throughput is one token per cycle.
- `tok_ready` drops in the cycle after an end token, offending token or illegal token is accepted.
- ERR is entered in cycle N+1 after an offending token at cycle N.
- End at N with `last_halt`: CHECK at N+1, DONE or ERR at N+2.
- End at N without `last_halt`: FINISH at N+1, HALT write pulse at N+2, CHECK at N+2, final state at N+3.
- `busy` is high throughout LOAD, FINISH and CHECK.

## Test plan
- Load kMOVE r1,5; label 3; kADDI 1; kBEZ 3; kHALT; end. Required: imem[0..3] hold the packed words, jt[3]=1, `inst_count`=4, `done` 2 cycles after end, no appended HALT.
- Omit the final kHALT. Required: `{kHALT,0}` written at address 3 in the FINISH cycle, `inst_count`=4, `done`.
- Forward kJUMP 7 with label 7 never defined. Required: `error`=1, `error_code`=11, `done`=0.
- Define label 2 twice. Required: ERR 10 in the cycle after the second definition, no second `jt_we`, `tok_ready`=0.
- Send 512 instructions, then a 513th. Required: no write for the 513th, `error_code`=01, `inst_count`=512.
- Assert `reset` mid-LOAD after 3 writes, then `start`. Required: all outputs at reset values, and reload begins at address 0. Kind 11 token: ERR 00.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: streaming program loader. Packs instruction tokens into
// {op,arg} words for instruction memory, fills the jump table from label
// tokens, appends a HALT when the program lacks one, and checks every
// referenced label was defined before reporting completion.
module inst_encoder (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [1:0] tok_kind,
  input  logic [3:0] tok_op,
  input  logic [4:0] tok_arg,
  output logic       imem_we,
  output logic [8:0] imem_addr,
  output logic [8:0] imem_wdata,
  output logic       jt_we,
  output logic [4:0] jt_addr,
  output logic [8:0] jt_wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] error_code,
  output logic [9:0] inst_count
);

  localparam int unsigned IMEM_DEPTH = 512;
  localparam int unsigned JT_ENTRIES = 32;
  localparam int unsigned PC_W       = 9;
  localparam int unsigned CNT_W      = 10;

  // Opcode values from the machine definitions
  localparam logic [3:0] K_MOVE  = 4'd0;
  localparam logic [3:0] K_BEO   = 4'd10;
  localparam logic [3:0] K_BEZ   = 4'd11;
  localparam logic [3:0] K_JUMP  = 4'd12;
  localparam logic [3:0] K_HALT  = 4'd13;
  localparam logic [3:0] K_OR    = 4'd15;

  localparam logic [1:0] KIND_INST  = 2'b00;
  localparam logic [1:0] KIND_LABEL = 2'b01;
  localparam logic [1:0] KIND_END   = 2'b10;

  localparam logic [1:0] ERR_ILLEGAL = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DUP     = 2'b10;
  localparam logic [1:0] ERR_UNDEF   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FINISH, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        pc, pc_next;
  logic [JT_ENTRIES-1:0]   defined, defined_next;
  logic [JT_ENTRIES-1:0]   referenced, referenced_next;
  logic                    last_halt, last_halt_next;

  logic                    imem_we_next, jt_we_next;
  logic [PC_W-1:0]         imem_addr_next, imem_wdata_next, jt_wdata_next;
  logic [4:0]              jt_addr_next;
  logic [1:0]              error_code_next;
  logic                    tok_ready_next, busy_next, done_next, error_next;

  logic                    accept;
  logic                    pc_full;
  logic                    unresolved;
  logic                    is_branch;

  assign accept     = tok_valid && tok_ready;
  assign pc_full    = (pc == CNT_W'(IMEM_DEPTH));
  assign unresolved = |(referenced & ~defined);
  assign is_branch  = (tok_op == K_BEO) || (tok_op == K_BEZ) || (tok_op == K_JUMP);
  assign inst_count = pc;

  // State, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      defined    <= '0;
      referenced <= '0;
      last_halt  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      jt_we      <= 1'b0;
      jt_addr    <= '0;
      jt_wdata   <= '0;
      tok_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      defined    <= defined_next;
      referenced <= referenced_next;
      last_halt  <= last_halt_next;
      imem_we    <= imem_we_next;
      imem_addr  <= imem_addr_next;
      imem_wdata <= imem_wdata_next;
      jt_we      <= jt_we_next;
      jt_addr    <= jt_addr_next;
      jt_wdata   <= jt_wdata_next;
      tok_ready  <= tok_ready_next;
      busy       <= busy_next;
      done       <= done_next;
      error      <= error_next;
      error_code <= error_code_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          case (tok_kind)
            KIND_INST:  if (pc_full) state_next = S_ERR;
            KIND_LABEL: if (pc_full || defined[tok_arg]) state_next = S_ERR;
            KIND_END:   state_next = last_halt ? S_CHECK : S_FINISH;
            default:    state_next = S_ERR;
          endcase
        end
      end
      S_FINISH: state_next = pc_full ? S_ERR : S_CHECK;
      S_CHECK:  state_next = unresolved ? S_ERR : S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Write strobes, bookkeeping updates and status for the next cycle
  always_comb begin
    pc_next         = pc;
    defined_next    = defined;
    referenced_next = referenced;
    last_halt_next  = last_halt;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    imem_wdata_next = imem_wdata;
    jt_we_next      = 1'b0;
    jt_addr_next    = jt_addr;
    jt_wdata_next   = jt_wdata;
    error_code_next = error_code;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          pc_next         = '0;
          defined_next    = '0;
          referenced_next = '0;
          last_halt_next  = 1'b0;
          error_code_next = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          case (tok_kind)
            KIND_INST: begin
              if (pc_full) begin
                error_code_next = ERR_OVF;
              end else begin
                imem_we_next    = 1'b1;
                imem_addr_next  = pc[PC_W-1:0];
                imem_wdata_next = {tok_op, tok_arg};
                pc_next         = pc + CNT_W'(1);
                last_halt_next  = (tok_op == K_HALT);
                if (is_branch) referenced_next[tok_arg] = 1'b1;
              end
            end
            KIND_LABEL: begin
              if (pc_full) begin
                error_code_next = ERR_OVF;
              end else if (defined[tok_arg]) begin
                error_code_next = ERR_DUP;
              end else begin
                jt_we_next             = 1'b1;
                jt_addr_next           = tok_arg;
                jt_wdata_next          = pc[PC_W-1:0];
                defined_next[tok_arg]  = 1'b1;
              end
            end
            KIND_END: ;
            default: error_code_next = ERR_ILLEGAL;
          endcase
        end
      end
      S_FINISH: begin
        if (pc_full) begin
          error_code_next = ERR_OVF;
        end else begin
          imem_we_next    = 1'b1;
          imem_addr_next  = pc[PC_W-1:0];
          imem_wdata_next = {K_HALT, 5'd0};
          pc_next         = pc + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (unresolved) error_code_next = ERR_UNDEF;
      end
      default: ;
    endcase

    tok_ready_next = (state_next == S_LOAD);
    busy_next      = (state_next == S_LOAD) || (state_next == S_FINISH) ||
                     (state_next == S_CHECK);
    done_next      = (state_next == S_DONE);
    error_next     = (state_next == S_ERR);
  end

  // Opcode range endpoints kept for reference of the full encoding
  logic unused_ops;
  assign unused_ops = ^{K_MOVE, K_OR};

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: token tables with per-token expected
// write strobes, plus hand sequences for FINISH, CHECK, overflow and reset.
module tb_inst_encoder;

  localparam logic [3:0] K_MOVE = 4'd0;
  localparam logic [3:0] K_ADDI = 4'd4;
  localparam logic [3:0] K_BEZ  = 4'd11;
  localparam logic [3:0] K_JUMP = 4'd12;
  localparam logic [3:0] K_HALT = 4'd13;

  logic       CLK, reset, start, tok_valid, tok_ready;
  logic [1:0] tok_kind;
  logic [3:0] tok_op;
  logic [4:0] tok_arg;
  logic       imem_we, jt_we, busy, done, error;
  logic [8:0] imem_addr, imem_wdata, jt_wdata;
  logic [4:0] jt_addr;
  logic [1:0] error_code;
  logic [9:0] inst_count;

  inst_encoder dut (
    .CLK(CLK), .reset(reset), .start(start),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_op(tok_op), .tok_arg(tok_arg),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .jt_we(jt_we), .jt_addr(jt_addr), .jt_wdata(jt_wdata),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .inst_count(inst_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] op;
    logic [4:0] arg;
    logic       ew_i;
    logic       ew_j;
    logic [8:0] addr;
    logic [8:0] data;
  } vec_t;

  vec_t vecs [0:15];
  int   nvec;
  int   passed, total;

  logic [8:0] imem_m [0:511];
  logic [8:0] jt_m   [0:31];
  int         n_imem, n_jt;
  logic       dual;

  // Memory model fed by the write ports
  always @(negedge CLK) begin
    if (imem_we) begin imem_m[imem_addr] = imem_wdata; n_imem++; end
    if (jt_we)   begin jt_m[jt_addr] = jt_wdata; n_jt++; end
    if (imem_we && jt_we) dual = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [1:0] k, input logic [3:0] op, input logic [4:0] arg,
                     input logic ei, input logic ej, input logic [8:0] addr, input logic [8:0] data);
    vecs[nvec] = '{kind: k, op: op, arg: arg, ew_i: ei, ew_j: ej, addr: addr, data: data};
    nvec++;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < nvec; i++) begin
      tok_valid = 1'b1;
      tok_kind  = vecs[i].kind;
      tok_op    = vecs[i].op;
      tok_arg   = vecs[i].arg;
      @(negedge CLK);
      check($sformatf("%s_v%0d_imem_we", tag, i), 32'(imem_we), 32'(vecs[i].ew_i));
      check($sformatf("%s_v%0d_jt_we", tag, i), 32'(jt_we), 32'(vecs[i].ew_j));
      if (vecs[i].ew_i) begin
        check($sformatf("%s_v%0d_imem_addr", tag, i), 32'(imem_addr), 32'(vecs[i].addr));
        check($sformatf("%s_v%0d_imem_data", tag, i), 32'(imem_wdata), 32'(vecs[i].data));
      end
      if (vecs[i].ew_j) begin
        check($sformatf("%s_v%0d_jt_addr", tag, i), 32'(jt_addr), 32'(vecs[i].addr));
        check($sformatf("%s_v%0d_jt_data", tag, i), 32'(jt_wdata), 32'(vecs[i].data));
      end
    end
    tok_valid = 1'b0;
    nvec = 0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n_imem = 0;
    n_jt = 0;
    check({tag, "_ready_after_start"}, 32'(tok_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tok_ready"}, 32'(tok_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_jt_we"}, 32'(jt_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_error_code"}, 32'(error_code), 32'd0);
    check({tag, "_inst_count"}, 32'(inst_count), 32'd0);
    check({tag, "_addr_data"}, {imem_addr, imem_wdata, jt_addr, jt_wdata},
          32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0; total = 0; nvec = 0; n_imem = 0; n_jt = 0; dual = 1'b0;
    reset = 1'b1; start = 1'b0; tok_valid = 1'b0;
    tok_kind = '0; tok_op = '0; tok_arg = '0;
    repeat (2) @(negedge CLK);
    check_reset_vals("rst0");
    reset = 1'b0;
    @(negedge CLK);

    // Program ending in HALT: no appended word, done two cycles after end
    do_start("t1");
    add(2'b00, K_MOVE, 5'd5, 1, 0, 9'd0, 9'd5);
    add(2'b01, 4'd0,   5'd3, 0, 1, 9'd3, 9'd1);
    add(2'b00, K_ADDI, 5'd1, 1, 0, 9'd1, 9'd129);
    add(2'b00, K_BEZ,  5'd3, 1, 0, 9'd2, 9'd355);
    add(2'b00, K_HALT, 5'd0, 1, 0, 9'd3, 9'd416);
    add(2'b10, 4'd0,   5'd0, 0, 0, 9'd0, 9'd0);
    run_vecs("t1");
    check("t1_busy_check", 32'(busy), 32'd1);
    check("t1_ready_drop", 32'(tok_ready), 32'd0);
    check("t1_not_done_yet", 32'(done), 32'd0);
    @(negedge CLK);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_inst_count", 32'(inst_count), 32'd4);
    check("t1_imem0", 32'(imem_m[0]), 32'd5);
    check("t1_imem3", 32'(imem_m[3]), 32'd416);
    check("t1_jt3", 32'(jt_m[3]), 32'd1);
    check("t1_n_imem", 32'(n_imem), 32'd4);

    // Missing HALT: FINISH appends {HALT,0} at address 3
    do_start("t2");
    add(2'b00, K_MOVE, 5'd5, 1, 0, 9'd0, 9'd5);
    add(2'b01, 4'd0,   5'd0, 0, 1, 9'd0, 9'd1);
    add(2'b00, K_ADDI, 5'd1, 1, 0, 9'd1, 9'd129);
    add(2'b00, K_JUMP, 5'd0, 1, 0, 9'd2, 9'd384);
    add(2'b10, 4'd0,   5'd0, 0, 0, 9'd0, 9'd0);
    run_vecs("t2");
    check("t2_finish_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("t2_halt_we", 32'(imem_we), 32'd1);
    check("t2_halt_addr", 32'(imem_addr), 32'd3);
    check("t2_halt_data", 32'(imem_wdata), 32'd416);
    check("t2_inst_count", 32'(inst_count), 32'd4);
    @(negedge CLK);
    check("t2_done", 32'(done), 32'd1);
    check("t2_no_error", 32'(error), 32'd0);

    // Forward jump to a label never defined
    do_start("t3");
    add(2'b00, K_JUMP, 5'd7, 1, 0, 9'd0, 9'd391);
    add(2'b00, K_HALT, 5'd0, 1, 0, 9'd1, 9'd416);
    add(2'b10, 4'd0,   5'd0, 0, 0, 9'd0, 9'd0);
    run_vecs("t3");
    @(negedge CLK);
    check("t3_error", 32'(error), 32'd1);
    check("t3_code", 32'(error_code), 32'd3);
    check("t3_done", 32'(done), 32'd0);

    // Duplicate label definition
    do_start("t4");
    add(2'b01, 4'd0,   5'd2, 0, 1, 9'd2, 9'd0);
    add(2'b00, K_MOVE, 5'd1, 1, 0, 9'd0, 9'd1);
    add(2'b01, 4'd0,   5'd2, 0, 0, 9'd0, 9'd0);
    run_vecs("t4");
    check("t4_error", 32'(error), 32'd1);
    check("t4_code", 32'(error_code), 32'd2);
    check("t4_ready", 32'(tok_ready), 32'd0);
    @(negedge CLK);
    check("t4_n_jt", 32'(n_jt), 32'd1);

    // Fill all 512 slots, then overflow on the 513th
    do_start("t5");
    for (int i = 0; i < 512; i++) begin
      tok_valid = 1'b1; tok_kind = 2'b00; tok_op = K_MOVE; tok_arg = 5'(i);
      @(negedge CLK);
    end
    check("t5_last_addr", 32'(imem_addr), 32'd511);
    tok_arg = 5'd1;
    @(negedge CLK);
    tok_valid = 1'b0;
    check("t5_no_write", 32'(imem_we), 32'd0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_code", 32'(error_code), 32'd1);
    check("t5_inst_count", 32'(inst_count), 32'd512);
    @(negedge CLK);
    check("t5_n_imem", 32'(n_imem), 32'd512);
    check("t5_imem511", 32'(imem_m[511]), 32'd31);
    check("t5_imem300", 32'(imem_m[300]), 32'd12);

    // Reset mid-load, reload from address 0, then an illegal token
    do_start("t6");
    for (int i = 1; i <= 3; i++) begin
      tok_valid = 1'b1; tok_kind = 2'b00; tok_op = K_MOVE; tok_arg = 5'(i);
      @(negedge CLK);
    end
    tok_valid = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    check_reset_vals("t6_rst");
    reset = 1'b0;
    do_start("t6b");
    add(2'b00, K_MOVE, 5'd9, 1, 0, 9'd0, 9'd9);
    add(2'b11, 4'd0,   5'd0, 0, 0, 9'd0, 9'd0);
    run_vecs("t6");
    check("t6_error", 32'(error), 32'd1);
    check("t6_code", 32'(error_code), 32'd0);
    check("t6_ready", 32'(tok_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    check("no_dual_strobe", 32'(dual), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
